// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage program-counter unit.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } pc_state_t;

  localparam int          PC_XLEN         = 32;
  localparam int          PC_INC          = 4;
  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_reg.sv
// Load-enabled register with asynchronous active-low reset to a fixed value.
module pc_reg #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage PC unit: BOOT/RUN/TRAP FSM, next-PC selection and EPC capture.
// Optional PC_MISALIGN_CHECK_EN turns misaligned redirects into a trap.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = PC_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(PC_TRAP_VECTOR),
  parameter int              INC          = PC_INC
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            trap_i,
  input  logic            mret_i,
  input  logic            fetch_ack_i,
  output logic            fetch_req_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_inc_o,
  output logic [XLEN-1:0] epc_o,
  output logic [1:0]      state_o,
  output logic            misalign_o
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, epc_q;
  logic            pc_en, epc_en;
  logic            redir;
  logic [XLEN-1:0] redir_tgt;
`ifdef PC_MISALIGN_CHECK_EN
  logic            misalign_d, misalign_q;
`endif

  // mret outranks a branch, so its target wins when both are raised
  assign redir     = mret_i | br_taken_i;
  assign redir_tgt = mret_i ? epc_q : br_target_i;

  assign pc_plus_inc_o = pc_q + XLEN'(INC);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pc_en   = 1'b0;
    pc_d    = pc_q;
    epc_en  = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      RUN: begin
        if (trap_i) begin
          epc_en  = 1'b1;
          pc_en   = 1'b1;
          pc_d    = TRAP_VECTOR;
          state_d = TRAP;
        end else if (redir) begin
`ifdef PC_MISALIGN_CHECK_EN
          if (|redir_tgt[1:0]) begin
            epc_en     = 1'b1;
            pc_en      = 1'b1;
            pc_d       = TRAP_VECTOR;
            state_d    = TRAP;
            misalign_d = 1'b1;
          end else begin
            pc_en = 1'b1;
            pc_d  = redir_tgt;
          end
`else
          pc_en = 1'b1;
          pc_d  = redir_tgt & ~XLEN'(3);
`endif
        end else if (!stall_i && fetch_ack_i) begin
          pc_en = 1'b1;
          pc_d  = pc_plus_inc_o;
        end
      end
      // BOOT and the TRAP bubble both last exactly one cycle
      default: state_d = RUN;
    endcase
  end

  pc_reg #(.W(XLEN), .RST_VAL(RESET_VECTOR)) u_pc (
    .CLK  (CLK),
    .RST_N(RST_N),
    .en   (pc_en),
    .d    (pc_d),
    .q    (pc_q)
  );

  pc_reg #(.W(XLEN), .RST_VAL('0)) u_epc (
    .CLK  (CLK),
    .RST_N(RST_N),
    .en   (epc_en),
    .d    (pc_q),
    .q    (epc_q)
  );

`ifdef PC_MISALIGN_CHECK_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign pc_o        = pc_q;
  assign epc_o       = epc_q;
  assign state_o     = state_q;
  assign fetch_req_o = (state_q == RUN);

endmodule

// File: tb/tb_pc_unit.sv
// Randomized bench for pc_unit against a behavioural PC model, plus directed literal checks.
module tb_pc_unit;

  localparam logic [31:0] TV = 32'h0000_0100;

  logic        CLK, RST_N;
  logic        stall_i, br_taken_i, trap_i, mret_i, fetch_ack_i;
  logic [31:0] br_target_i;
  logic        fetch_req_o, misalign_o;
  logic [31:0] pc_o, pc_plus_inc_o, epc_o;
  logic [1:0]  state_o;

  pc_unit dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .stall_i      (stall_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .trap_i       (trap_i),
    .mret_i       (mret_i),
    .fetch_ack_i  (fetch_ack_i),
    .fetch_req_o  (fetch_req_o),
    .pc_o         (pc_o),
    .pc_plus_inc_o(pc_plus_inc_o),
    .epc_o        (epc_o),
    .state_o      (state_o),
    .misalign_o   (misalign_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [1:0]  st;   // 0 boot, 1 run, 2 trap bubble
    logic        mis;
  } ms_t;

  localparam ms_t RESET_MS = '{pc: 32'h0, epc: 32'h0, st: 2'd0, mis: 1'b0};

  ms_t m;
  int  n_chk  = 0;
  int  n_fail = 0;
  bit  chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of the architectural rules applied to the current model state.
  function automatic ms_t model_step(input ms_t c, input bit trap, input bit mret, input bit br,
                                     input bit stall, input bit ack, input logic [31:0] btgt);
    ms_t n;
    logic [31:0] tgt;
    n = c;
    n.mis = 1'b0;
    if (c.st != 2'd1) begin
      n.st = 2'd1;
    end else if (trap) begin
      n.epc = c.pc;
      n.pc  = TV;
      n.st  = 2'd2;
    end else if (mret || br) begin
      tgt = mret ? c.epc : btgt;
`ifdef PC_MISALIGN_CHECK_EN
      if (tgt % 4 != 0) begin
        n.epc = c.pc;
        n.pc  = TV;
        n.st  = 2'd2;
        n.mis = 1'b1;
      end else begin
        n.pc = tgt;
      end
`else
      n.pc = (tgt / 4) * 4;
`endif
    end else if (!stall && ack) begin
      n.pc = c.pc + 32'd4;
    end
    return n;
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("pc_o", pc_o, m.pc);
      chk("epc_o", epc_o, m.epc);
      chk("state_o", 32'(state_o), 32'(m.st));
      chk("fetch_req_o", 32'(fetch_req_o), 32'(m.st == 2'd1));
      chk("pc_plus_inc_o", pc_plus_inc_o, m.pc + 32'd4);
      chk("misalign_o", 32'(misalign_o), 32'(m.mis));
    end
  end

  task automatic apply(input bit trap, input bit mret, input bit br, input logic [31:0] tgt,
                       input bit stall, input bit ack);
    ms_t nxt;
    trap_i      = trap;
    mret_i      = mret;
    br_taken_i  = br;
    br_target_i = tgt;
    stall_i     = stall;
    fetch_ack_i = ack;
    nxt = model_step(m, trap, mret, br, stall, ack, tgt);
    @(posedge CLK);
    #1 m = nxt;
  endtask

  task automatic drive(input bit trap, input bit mret, input bit br, input logic [31:0] tgt,
                       input bit stall, input bit ack);
    @(negedge CLK);
    apply(trap, mret, br, tgt, stall, ack);
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("boot_state", 32'(state_o), 32'd0);
    chk("boot_req", 32'(fetch_req_o), 32'd0);
    chk("boot_pc", pc_o, 32'h0);
    apply(0, 0, 0, 32'h0, 0, 0);
    chk("run_state", 32'(state_o), 32'd1);
    chk("run_req", 32'(fetch_req_o), 32'd1);
  endtask

  task automatic random_phase(input int n);
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t = t & ~32'd3;
      if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFFC;
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0,
            t, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    stall_i = 0; br_taken_i = 0; trap_i = 0; mret_i = 0; fetch_ack_i = 0;
    br_target_i = 32'h0;
    m = RESET_MS;
    repeat (3) @(negedge CLK);
    chk_en = 1;
    #1;
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_epc", epc_o, 32'h0);
    chk("rst_req", 32'(fetch_req_o), 32'd0);

    release_reset();

    // sequential advance then stall
    drive(0, 0, 0, 32'h0, 0, 1);  chk("seq_pc1", pc_o, 32'h4);
    drive(0, 0, 0, 32'h0, 0, 1);  chk("seq_pc2", pc_o, 32'h8);
    drive(0, 0, 0, 32'h0, 0, 1);  chk("seq_pc3", pc_o, 32'hC);
    drive(0, 0, 0, 32'h0, 1, 1);  chk("stall_pc", pc_o, 32'hC);

    // priority: trap beats mret and branch
    drive(0, 0, 1, 32'h40, 0, 0); chk("br_pc", pc_o, 32'h40);
    drive(1, 1, 1, 32'h80, 0, 1);
    chk("prio_epc", epc_o, 32'h40);
    chk("prio_pc", pc_o, 32'h100);
    chk("prio_req", 32'(fetch_req_o), 32'd0);
    drive(0, 0, 0, 32'h0, 0, 1);
    chk("bubble_pc", pc_o, 32'h100);
    chk("bubble_req", 32'(fetch_req_o), 32'd1);
    drive(0, 1, 0, 32'h0, 0, 1);  chk("mret_pc", pc_o, 32'h40);

    // wrap
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, 1);
    chk("wrap_pre", pc_o, 32'hFFFF_FFFC);
    chk("wrap_inc_pre", pc_plus_inc_o, 32'h0);
    drive(0, 0, 0, 32'h0, 0, 1);
    chk("wrap_pc", pc_o, 32'h0);
    chk("wrap_inc", pc_plus_inc_o, 32'h4);

    // misaligned branch
    drive(0, 0, 1, 32'h20, 0, 0);
    drive(0, 0, 1, 32'h82, 0, 1);
`ifdef PC_MISALIGN_CHECK_EN
    chk("mis_pulse", 32'(misalign_o), 32'd1);
    chk("mis_epc", epc_o, 32'h20);
    chk("mis_pc", pc_o, 32'h100);
`else
    chk("mis_pulse", 32'(misalign_o), 32'd0);
    chk("mis_pc", pc_o, 32'h80);
`endif
    drive(0, 0, 0, 32'h0, 1, 0);
    chk("mis_clear", 32'(misalign_o), 32'd0);

    random_phase(400);

    // asynchronous reset in the middle of the trap bubble
    drive(1, 0, 0, 32'h0, 0, 0);
    chk("pre_rst_state", 32'(state_o), 32'd2);
    #1 RST_N = 1'b0;
    m = RESET_MS;
    #1;
    chk("arst_pc", pc_o, 32'h0);
    chk("arst_epc", epc_o, 32'h0);
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_req", 32'(fetch_req_o), 32'd0);
    @(negedge CLK);
    release_reset();

    random_phase(400);

    @(negedge CLK);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the RISC-V core's fetch stage. It holds the PC and selects the next PC from sequential advance, branch/jump redirect, trap entry or trap return. It drives a req/ack handshake to instruction memory and captures the exception PC (EPC). It replaces the plain load-every-cycle PC register with stall, redirect, trap and boot handling.

## Interface
- XLEN, 32, PC/address width
- RESET_VECTOR, 32'h0000_0000, PC value while in reset and in BOOT
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry
- INC, 4, sequential PC increment (bytes)

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- stall_i  in  1  pipeline stall; holds PC, no sequential advance
- br_taken_i  in  1  branch/jump redirect request from execute
- br_target_i  in  XLEN  redirect target
- trap_i  in  1  exception/interrupt request
- mret_i  in  1  return from trap to epc_o
- fetch_ack_i  in  1  instruction memory accepted the fetch at pc_o
- fetch_req_o  out  1  fetch request valid for pc_o
- pc_o  out  XLEN  current PC (registered)
- pc_plus_inc_o  out  XLEN  pc_o + INC, modulo 2^XLEN (combinational from pc_o)
- epc_o  out  XLEN  PC saved at last trap entry (registered)
- state_o  out  2  FSM state (BOOT=0, RUN=1, TRAP=2)
- misalign_o  out  1  one-cycle pulse on misaligned redirect (macro only, else tied 0)

## Operation
- Reset (RST_N=0, immediate): pc_o=RESET_VECTOR, epc_o=0, state=BOOT, fetch_req_o=0, misalign_o=0.
- fetch_req_o = (state==RUN); decoded from the state register, so no combinational input-to-output path.
- BOOT: one cycle after reset release, then ->RUN. All requests are ignored and pc_o is unchanged.
- RUN: event priority, highest first; exactly one action per cycle:
  - trap_i: epc_o<=pc_o, pc_o<=TRAP_VECTOR, ->TRAP.
  - mret_i: pc_o<=epc_o, stay RUN.
  - br_taken_i: pc_o<=br_target_i, stay RUN. The outstanding fetch is abandoned; fetch_ack_i in the same cycle is ignored.
  - stall_i: hold pc_o.
  - fetch_ack_i: pc_o<=pc_o+INC (wraps to 0).
  - else hold.
- Redirects (trap, mret, branch) ignore stall_i and fetch_ack_i.
- TRAP: one bubble cycle with fetch_req_o=0, ->RUN unconditionally. All requests are ignored and pc_o holds TRAP_VECTOR.
- Arithmetic is unsigned XLEN-bit with carry discarded.

## Timing
- All outputs except pc_plus_inc_o are registered. A request sampled at edge N is visible on pc_o after edge N.
- Advance latency: fetch_ack_i high at edge N gives pc_o+INC after edge N.
- From reset release: the first edge enters RUN, and fetch_req_o is high from then on.
- Trap: fetch_req_o is low for exactly one cycle. The first fetch of TRAP_VECTOR is requested in the cycle after that.
- Asserting RST_N low mid-operation, in any state, immediately restores reset values. epc_o is lost.

## Configuration
- PC_MISALIGN_CHECK_EN defined:
  - A branch or mret target with bits [1:0]!=0 is not taken.
  - Instead: epc_o<=pc_o, pc_o<=TRAP_VECTOR, ->TRAP, and misalign_o pulses for one cycle.
  - trap_i still has the highest priority.
- Undefined: redirect targets are used with bits [1:0] forced to 0, and misalign_o is tied 0.

## Structure
- Package pc_pkg:
  - state enum pc_state_t {BOOT, RUN, TRAP}, 2 bits
  - default XLEN and INC localparams
  - default vector constants
- Sub-module pc_reg: XLEN-wide register with async active-low reset to a parameter value and a load enable. Instantiated twice, for pc_o and epc_o.
- pc_unit holds the FSM and the next-PC mux.

## Test plan
- Reset/boot: hold RST_N=0 for 3 cycles, then release -> pc_o=0, fetch_req_o=0 in BOOT; RUN after one edge, fetch_req_o=1.
- Sequential with stall: ack for 3 cycles -> pc_o 0,4,8,C. Then stall_i=1 with ack=1 -> pc_o holds 0xC.
- Priority: at pc=0x40, assert trap_i, mret_i and br_taken_i (target 0x80) together -> epc_o=0x40, pc_o=0x100, one bubble cycle; then mret_i -> pc_o=0x40.
- Wrap: force pc_o to 0xFFFF_FFFC via branch, then ack -> pc_o=0x0000_0000, pc_plus_inc_o=0x4.
- Misalign (macro on): br_target_i=0x82 at pc=0x20 -> misalign_o pulse, epc_o=0x20, pc_o=0x100. Macro off: pc_o=0x80.
- Async reset mid-TRAP: drop RST_N between edges -> pc_o=RESET_VECTOR, epc_o=0, state BOOT without waiting for a clock edge.
